// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard inputs and pipeline-register controls of the Y86-64 pipe_ctrl block
interface pipe_ctrl_if;
  // Hazard sources sampled from the D/E/M/W pipeline registers and stage logic
  logic [3:0] D_icode;
  logic [3:0] d_srcA;
  logic [3:0] d_srcB;
  logic [3:0] E_icode;
  logic [3:0] E_dstM;
  logic       e_Cnd;
  logic [3:0] M_icode;
  logic [2:0] m_stat;
  logic [2:0] W_stat;

  // Controls returned to the pipeline registers
  logic       F_stall;
  logic       D_stall;
  logic       D_bubble;
  logic       E_bubble;
  logic       M_bubble;
  logic       W_stall;
  logic       set_cc;
  logic       halted;
  logic [1:0] ctrl_state;

  // Datapath side: supplies hazard sources, consumes controls
  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted, ctrl_state
  );

  // Control unit side
  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted, ctrl_state
  );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86-64 pipeline hazard control, reset flush and halt sequencer; PIPE_CTRL_PERF_EN adds perf counters
module pipe_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.slave       pif
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt
`endif
);

  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_IRET   = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [2:0] S_HLT    = 3'd2;
  localparam logic [2:0] S_ADR    = 3'd3;
  localparam logic [2:0] S_INS    = 3'd4;
  localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // The flush counter is only 4 bits wide, so reject lengths it cannot hold
  if (INIT_CYCLES < 1 || INIT_CYCLES > 15 || CNT_W < 1) begin : g_param_check
    $error("pipe_ctrl: illegal parameter value");
  end

  state_t     state_q, state_d;
  logic [3:0] init_cnt_q, init_cnt_d;
  logic       lu, ret, mp, mexc, wexc;

  // Hazard terms from the current register contents
  assign lu   = ((pif.E_icode == I_MRMOVQ) || (pif.E_icode == I_POPQ)) &&
                (pif.E_dstM != RNONE) &&
                ((pif.E_dstM == pif.d_srcA) || (pif.E_dstM == pif.d_srcB));
  assign ret  = (pif.D_icode == I_IRET) || (pif.E_icode == I_IRET) || (pif.M_icode == I_IRET);
  assign mp   = (pif.E_icode == I_JXX) && !pif.e_Cnd;
  assign mexc = (pif.m_stat == S_HLT) || (pif.m_stat == S_ADR) || (pif.m_stat == S_INS);
  assign wexc = (pif.W_stat == S_HLT) || (pif.W_stat == S_ADR) || (pif.W_stat == S_INS);

  // Sequencer state and flush counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= INIT_LOAD;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state: flush for INIT_CYCLES edges, run, and freeze once an exception retires
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == 4'd0) state_d = ST_RUN;
        else                    init_cnt_d = init_cnt_q - 4'd1;
      end
      ST_RUN:  if (wexc) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_INIT;
    endcase
  end

  // Pipeline register controls; D stall yields to a mispredict bubble
  always_comb begin
    pif.F_stall  = 1'b0;
    pif.D_stall  = 1'b0;
    pif.D_bubble = 1'b0;
    pif.E_bubble = 1'b0;
    pif.M_bubble = 1'b0;
    pif.W_stall  = 1'b0;
    pif.set_cc   = 1'b0;
    case (state_q)
      ST_RUN: begin
        pif.F_stall  = lu | ret;
        pif.D_stall  = lu & !mp;
        pif.D_bubble = mp | (ret & !lu);
        pif.E_bubble = mp | lu;
        pif.M_bubble = mexc | wexc;
        pif.W_stall  = wexc;
        pif.set_cc   = (pif.E_icode == I_OPQ) & !mexc & !wexc;
      end
      ST_HALT: begin
        pif.F_stall  = 1'b1;
        pif.D_stall  = 1'b1;
        pif.M_bubble = 1'b1;
        pif.W_stall  = 1'b1;
      end
      default: begin
        pif.F_stall  = 1'b1;
        pif.D_bubble = 1'b1;
        pif.E_bubble = 1'b1;
        pif.M_bubble = 1'b1;
      end
    endcase
  end

  assign pif.halted     = (state_q == ST_HALT);
  assign pif.ctrl_state = state_q;

`ifdef PIPE_CTRL_PERF_EN
  // Saturating perf counters, advancing only while the pipeline runs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      lu_cnt  <= '0;
      mp_cnt  <= '0;
    end else if (state_q == ST_RUN) begin
      if (cyc_cnt != '1)       cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (lu && lu_cnt != '1)  lu_cnt  <= lu_cnt + CNT_W'(1);
      if (mp && mp_cnt != '1)  mp_cnt  <= mp_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
